// File: rtl/score_seg_display.sv
// Binary score to two active-low 7-segment digits using a sequential double-dabble converter.
// Optional feature: define SCORE_BLINK_EN to blink the digits in a burst after every latch.
module score_seg_display
`ifdef SCORE_BLINK_EN
#(
  parameter int c_BLINK_HALF_PERIOD = 6250000,
  parameter int c_BLINK_TOGGLES     = 6
)
`endif
(
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [7:0] i_Score,
  output logic [6:0] o_Seg_Tens,
  output logic [6:0] o_Seg_Ones,
  output logic       o_Busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  state_t      state_r;
  logic [7:0]  last_r;
  logic [7:0]  shift_r;
  logic [9:0]  bcd_r;
  logic [2:0]  cnt_r;
  logic        busy_r;
  logic [6:0]  latch_tens_s;
  logic [6:0]  latch_ones_s;

  function automatic logic [6:0] seg_enc(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  function automatic logic [3:0] dabble_adj(input logic [3:0] nibble);
    logic [3:0] res;
    if (nibble >= 4'd5) begin
      res = nibble + 4'd3;
    end else begin
      res = nibble;
    end
    return res;
  endfunction

  // The hundreds field of an 8-bit input never exceeds 2, so it needs no adjust.
  function automatic logic [9:0] dabble_step(input logic [9:0] bcd, input logic msb);
    logic [9:0] adj;
    adj = {bcd[9:8], dabble_adj(bcd[7:4]), dabble_adj(bcd[3:0])};
    return {adj[8:0], msb};
  endfunction

  assign latch_tens_s = (bcd_r[9:8] != 2'd0) ? SEG_DASH : seg_enc(bcd_r[7:4]);
  assign latch_ones_s = (bcd_r[9:8] != 2'd0) ? SEG_DASH : seg_enc(bcd_r[3:0]);
  assign o_Busy       = busy_r;

  // Conversion FSM: detect a score change, run eight dabble iterations, then latch.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_r <= IDLE;
      last_r  <= 8'd0;
      shift_r <= 8'd0;
      bcd_r   <= 10'd0;
      cnt_r   <= 3'd0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (i_Score != last_r) begin
            shift_r <= i_Score;
            last_r  <= i_Score;
            bcd_r   <= 10'd0;
            cnt_r   <= 3'd0;
            busy_r  <= 1'b1;
            state_r <= SHIFT;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          bcd_r   <= dabble_step(bcd_r, shift_r[7]);
          shift_r <= {shift_r[6:0], 1'b0};
          cnt_r   <= cnt_r + 3'd1;
          busy_r  <= 1'b1;
          if (cnt_r == 3'd7) begin
            state_r <= LATCH;
          end else begin
            state_r <= SHIFT;
          end
        end
        LATCH: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

`ifdef SCORE_BLINK_EN
  localparam int HW = $clog2(c_BLINK_HALF_PERIOD) + 1;
  localparam int TW = $clog2(c_BLINK_TOGGLES) + 1;

  logic [6:0]    dig_tens_r;
  logic [6:0]    dig_ones_r;
  logic [HW-1:0] half_cnt_r;
  logic [TW-1:0] toggles_left_r;
  logic          blank_r;

  // Latched digits plus the blink burst; a latch always restarts the burst in a blank half.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      dig_tens_r     <= SEG_ZERO;
      dig_ones_r     <= SEG_ZERO;
      half_cnt_r     <= {HW{1'b0}};
      toggles_left_r <= {TW{1'b0}};
      blank_r        <= 1'b0;
      o_Seg_Tens     <= SEG_ZERO;
      o_Seg_Ones     <= SEG_ZERO;
    end else if (state_r == LATCH) begin
      dig_tens_r     <= latch_tens_s;
      dig_ones_r     <= latch_ones_s;
      half_cnt_r     <= {HW{1'b0}};
      toggles_left_r <= TW'(c_BLINK_TOGGLES - 1);
      blank_r        <= 1'b1;
      o_Seg_Tens     <= SEG_BLANK;
      o_Seg_Ones     <= SEG_BLANK;
    end else if (toggles_left_r != {TW{1'b0}}) begin
      if (half_cnt_r == HW'(c_BLINK_HALF_PERIOD - 1)) begin
        half_cnt_r     <= {HW{1'b0}};
        toggles_left_r <= toggles_left_r - TW'(1);
        blank_r        <= ~blank_r;
        o_Seg_Tens     <= blank_r ? dig_tens_r : SEG_BLANK;
        o_Seg_Ones     <= blank_r ? dig_ones_r : SEG_BLANK;
      end else begin
        half_cnt_r     <= half_cnt_r + HW'(1);
      end
    end else begin
      o_Seg_Tens <= dig_tens_r;
      o_Seg_Ones <= dig_ones_r;
    end
  end
`else
  // Steady display: outputs change only when a conversion latches.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_Seg_Tens <= SEG_ZERO;
      o_Seg_Ones <= SEG_ZERO;
    end else if (state_r == LATCH) begin
      o_Seg_Tens <= latch_tens_s;
      o_Seg_Ones <= latch_ones_s;
    end else begin
      o_Seg_Tens <= o_Seg_Tens;
      o_Seg_Ones <= o_Seg_Ones;
    end
  end
`endif

endmodule
